// File: rtl/diff_backprop_pipe.sv
// Elastic DEPTH-stage register pipeline for the backprop diff bundle.
// It provides a valid/ready handshake with bubble squeezing, a synchronous flush and an occupancy count.
module diff_backprop_pipe #(
   parameter int size            = 3,
   parameter int data_size       = 16,
   parameter int dense_type_size = 4,
   parameter int DEPTH           = 2
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          flush,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [31:0]                   w_layer_index,
   input  logic [31:0]                   w_row_index,
   input  logic                          backprop_cost,
   input  logic [size*data_size-1:0]     diff_to_all,
   input  logic [size*data_size-1:0]     diff_start,
   input  logic [size*data_size-1:0]     diff_dense,
   input  logic [size*data_size-1:0]     diff_cost,
   input  logic [dense_type_size-1:0]    dense_type,
   input  logic                          is_update,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [31:0]                   w_layer_index_out,
   output logic [31:0]                   w_row_index_out,
   output logic                          backprop_cost_out,
   output logic [size*data_size-1:0]     diff_to_all_out,
   output logic [size*data_size-1:0]     diff_start_out,
   output logic [size*data_size-1:0]     diff_dense_out,
   output logic [size*data_size-1:0]     diff_cost_out,
   output logic [dense_type_size-1:0]    dense_type_out,
   output logic                          is_update_out,
   output logic [$clog2(DEPTH+1)-1:0]    occupancy
);

   localparam int VW = size * data_size;
   localparam int PW = 32 + 32 + 1 + 4 * VW + dense_type_size + 1;
   localparam int OW = $clog2(DEPTH + 1);

   logic [DEPTH-1:0] vld_p;
   logic [DEPTH-1:0] adv;
   logic [DEPTH-1:0] src_vld;
   logic [DEPTH-1:0] vld_next;
   logic [PW-1:0]    pay_p   [DEPTH];
   logic [PW-1:0]    src_pay [DEPTH];
   logic [PW-1:0]    pay_in;
   logic [OW-1:0]    occ_q;

   function automatic logic [OW-1:0] popcount(input logic [DEPTH-1:0] v);
      logic [OW-1:0] c;
      c = '0;
      for (int i = 0; i < DEPTH; i++) c = c + OW'(v[i]);
      return c;
   endfunction

   assign pay_in = {w_layer_index, w_row_index, backprop_cost, diff_to_all, diff_start,
                    diff_dense, diff_cost, dense_type, is_update};

   // A stage may advance unless it and every stage above it are full while the sink stalls.
   genvar k;
   for (k = 0; k < DEPTH; k++) begin : g_stage
      assign adv[k] = out_ready | ~(&vld_p[DEPTH-1:k]);
      if (k == 0) begin : g_head
         assign src_vld[k] = in_valid;
         assign src_pay[k] = pay_in;
      end else begin : g_body
         assign src_vld[k] = vld_p[k-1];
         assign src_pay[k] = pay_p[k-1];
      end
   end

   assign in_ready = adv[0] & ~flush;
   assign vld_next = flush ? '0 : ((adv & src_vld) | (~adv & vld_p));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p <= '0;
         occ_q <= '0;
      end else begin
         vld_p <= vld_next;
         occ_q <= popcount(vld_next);
      end
   end

   // Payload only moves behind a valid bit, and a flush leaves payload untouched.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) pay_p[i] <= '0;
      end else if (!flush) begin
         for (int i = 0; i < DEPTH; i++)
            if (adv[i] && src_vld[i]) pay_p[i] <= src_pay[i];
      end
   end

   assign out_valid = vld_p[DEPTH-1];
   assign occupancy = occ_q;
   assign {w_layer_index_out, w_row_index_out, backprop_cost_out, diff_to_all_out, diff_start_out,
           diff_dense_out, diff_cost_out, dense_type_out, is_update_out} = pay_p[DEPTH-1];

endmodule
